// File: rtl/manchester_frame_decoder.sv
// rtl/manchester_frame_decoder.sv - Manchester line decoder with preamble hunt and framed payload handshake
module manchester_frame_decoder #(
    parameter int                       HALF_BIT_CYCLES = 8,
    parameter int                       TOLERANCE       = 2,
    parameter int                       PREAMBLE_BITS   = 8,
    parameter logic [PREAMBLE_BITS-1:0] PREAMBLE        = 8'hA5,
    parameter int                       FRAME_BITS      = 32,
    parameter int                       TIMEOUT_CYCLES  = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  digital_in,
    input  logic                  frame_ready,
    input  logic                  clear_errors,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  frame_valid,
    output logic                  manchester_clock,
    output logic                  receiving,
    output logic                  err_timing,
    output logic                  err_timeout,
    output logic                  overrun
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam logic [CW:0]   SHORT_MIN   = (CW+1)'(HALF_BIT_CYCLES - TOLERANCE);
    localparam logic [CW:0]   SHORT_MAX   = (CW+1)'(HALF_BIT_CYCLES + TOLERANCE);
    localparam logic [CW:0]   LONG_MIN    = (CW+1)'(2 * HALF_BIT_CYCLES - TOLERANCE);
    localparam logic [CW:0]   LONG_MAX    = (CW+1)'(2 * HALF_BIT_CYCLES + TOLERANCE);
    localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);
    localparam logic [BW-1:0] LAST_BIT    = BW'(FRAME_BITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_HUNT, S_PAYLOAD, S_DELIVER} state_t;
    state_t state, state_next;

    logic                     sync_1, sync_2, line_prev;
    logic [CW-1:0]            interval_cnt;
    logic                     at_boundary, at_boundary_next;
    logic [PREAMBLE_BITS-1:0] hunt_window, hunt_next;
    logic [FRAME_BITS-1:0]    payload;
    logic [BW-1:0]            bit_cnt;

    logic          line_edge, polarity, timed_out, is_short, is_long;
    logic [CW:0]   interval;
    logic          accept, emit, set_timing, set_timeout, load_frame, set_overrun;

    assign line_edge = sync_2 ^ line_prev;
    assign polarity  = sync_2;
    assign timed_out = (interval_cnt == TIMEOUT_VAL);
    // The counter was cleared on the previous edge, so the elapsed clocks are one more than its value.
    assign interval  = {1'b0, interval_cnt} + {{CW{1'b0}}, 1'b1};
    assign is_short  = (interval >= SHORT_MIN) && (interval <= SHORT_MAX);
    assign is_long   = (interval >= LONG_MIN) && (interval <= LONG_MAX);
    assign hunt_next = {hunt_window[PREAMBLE_BITS-2:0], polarity};
    assign receiving = (state == S_PAYLOAD);

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next       = state;
        at_boundary_next = at_boundary;
        accept           = 1'b0;
        emit             = 1'b0;
        set_timing       = 1'b0;
        set_timeout      = 1'b0;
        load_frame       = 1'b0;
        set_overrun      = 1'b0;
        case (state)
            S_IDLE: begin
                if (line_edge) begin
                    accept           = 1'b1;
                    emit             = 1'b1;
                    at_boundary_next = 1'b0;
                    state_next       = S_HUNT;
                end
            end
            S_HUNT, S_PAYLOAD: begin
                if (timed_out) begin
                    state_next  = S_IDLE;
                    set_timeout = (state == S_PAYLOAD);
                end else if (line_edge) begin
                    if (is_short && !at_boundary) begin
                        accept           = 1'b1;
                        at_boundary_next = 1'b1;
                    end else if (is_short) begin
                        accept           = 1'b1;
                        emit             = 1'b1;
                        at_boundary_next = 1'b0;
                    end else if (is_long && !at_boundary) begin
                        accept = 1'b1;
                        emit   = 1'b1;
                    end else begin
                        set_timing = 1'b1;
                        state_next = S_IDLE;
                    end
                    if (emit) begin
                        if (state == S_HUNT && hunt_next == PREAMBLE)
                            state_next = S_PAYLOAD;
                        else if (state == S_PAYLOAD && bit_cnt == LAST_BIT)
                            state_next = S_DELIVER;
                    end
                end
            end
            S_DELIVER: begin
                state_next = S_IDLE;
                if (!frame_valid || frame_ready) load_frame  = 1'b1;
                else                             set_overrun = 1'b1;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_1           <= 1'b0;
            sync_2           <= 1'b0;
            line_prev        <= 1'b0;
            interval_cnt     <= '0;
            at_boundary      <= 1'b0;
            hunt_window      <= '0;
            payload          <= '0;
            bit_cnt          <= '0;
            frame_data       <= '0;
            frame_valid      <= 1'b0;
            manchester_clock <= 1'b0;
            err_timing       <= 1'b0;
            err_timeout      <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            sync_1    <= digital_in;
            sync_2    <= sync_1;
            line_prev <= sync_2;

            if (line_edge)       interval_cnt <= '0;
            else if (!timed_out) interval_cnt <= interval_cnt + CW'(1);

            at_boundary <= at_boundary_next;

            if (emit) begin
                if (state == S_IDLE) begin
                    hunt_window <= PREAMBLE_BITS'(polarity);
                end else if (state == S_HUNT) begin
                    hunt_window <= hunt_next;
                end else begin
                    payload <= {payload[FRAME_BITS-2:0], polarity};
                    bit_cnt <= bit_cnt + BW'(1);
                end
            end
            if (state == S_HUNT && state_next == S_PAYLOAD) bit_cnt <= '0;

            if (state_next == S_IDLE) manchester_clock <= 1'b0;
            else if (accept)          manchester_clock <= ~manchester_clock;

            // A clear in the same cycle as an error event wins and the event is dropped.
            if (clear_errors) begin
                err_timing  <= 1'b0;
                err_timeout <= 1'b0;
                overrun     <= 1'b0;
            end else begin
                if (set_timing)  err_timing  <= 1'b1;
                if (set_timeout) err_timeout <= 1'b1;
                if (set_overrun) overrun     <= 1'b1;
            end

            if (load_frame) begin
                frame_data  <= payload;
                frame_valid <= 1'b1;
            end else if (frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end
endmodule
